gate_selftest_seq: RTL and testbench

//  Sequential self-test driver and checker for the two-input basic-gate block.

---
 rtl/gate_selftest_seq_pkg.sv | 33 +++
 rtl/gate_selftest_seq_if.sv | 9 +
 rtl/gate_selftest_seq_settle_timer.sv | 28 ++
 rtl/gate_selftest_seq.sv | 141 ++++++++++++++
 tb/tb_gate_selftest_seq.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/gate_selftest_seq_pkg.sv
// Shared definitions for the gate-block self-test sequencer: result bit map, FSM encoding
// and the reference result bundle for a given operand pair.
package gate_selftest_pkg;

  localparam int RES_AND   = 0;
  localparam int RES_OR    = 1;
  localparam int RES_XOR   = 2;
  localparam int RES_NAND  = 3;
  localparam int RES_NOR   = 4;
  localparam int RES_XNOR  = 5;
  localparam int RES_NOT_A = 6;
  localparam int RES_NOT_B = 7;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  function automatic logic [7:0] expected_res(input logic a, input logic b);
    logic [7:0] r;
    r            = 8'h00;
    r[RES_AND]   = a & b;
    r[RES_OR]    = a | b;
    r[RES_XOR]   = a ^ b;
    r[RES_NAND]  = ~(a & b);
    r[RES_NOR]   = ~(a | b);
    r[RES_XNOR]  = ~(a ^ b);
    r[RES_NOT_A] = ~a;
    r[RES_NOT_B] = ~b;
    return r;
  endfunction

endpackage

// File: rtl/gate_selftest_seq_if.sv
// Operand/result bus between the self-test sequencer (master) and the gate block (slave).
interface gate_selftest_seq_if;
  logic       gate_a;
  logic       gate_b;
  logic [7:0] gate_res;

  modport master (output gate_a, output gate_b, input gate_res);
  modport slave  (input gate_a, input gate_b, output gate_res);
endinterface

// File: rtl/gate_selftest_seq_settle_timer.sv
// 4-bit settle down-counter; expired is high when the count is zero.
// The count holds the settle cycles remaining after the current one, so the load value is one less.
module gate_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_expired
);

  localparam logic [3:0] LOAD_VAL = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

  logic [3:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_expired = (r_cnt == 4'd0);

endmodule

// File: rtl/gate_selftest_seq.sv
// Self-test driver/checker for the two-input gate block: sweeps ab=00..11, compares results.
// Optional first-failure capture ports when GATE_SELFTEST_LOG_EN is defined.
module gate_selftest_seq
  import gate_selftest_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_PASSES    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  gate_selftest_seq_if.master  gate_bus,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
`ifdef GATE_SELFTEST_LOG_EN
  output logic                 first_fail_valid,
  output logic [1:0]           first_fail_ab,
  output logic [7:0]           first_fail_res,
`endif
  output logic [7:0]           fail_vec
);

  localparam logic [3:0] LAST_PASS = 4'(NUM_PASSES - 1);
  // With no settle time every vector goes straight to its sample cycle.
  localparam logic [1:0] ST_WAIT   = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;

  logic [1:0] r_state;
  logic [1:0] r_vec;
  logic [3:0] r_pass_cnt;
  logic [1:0] r_ab;
  logic       r_busy;
  logic       r_pass;
  logic [7:0] r_fail_vec;

  logic [7:0] w_mismatch;
  logic [7:0] w_fail_nxt;
  logic       w_accept;
  logic       w_last;
  logic       w_continue;
  logic       w_expired;

  assign w_mismatch = gate_bus.gate_res ^ expected_res(r_ab[1], r_ab[0]);
  assign w_fail_nxt = r_fail_vec | w_mismatch;
  assign w_accept   = (r_state == ST_IDLE) && start;
  assign w_last     = (r_vec == 2'd3) && (r_pass_cnt >= LAST_PASS);
  assign w_continue = (r_state == ST_SAMPLE) && !w_last;

  gate_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_accept | w_continue),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_vec      <= 2'd0;
      r_pass_cnt <= 4'd0;
      r_ab       <= 2'b00;
      r_busy     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail_vec <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_busy     <= 1'b1;
            r_pass     <= 1'b0;
            r_fail_vec <= 8'h00;
            r_vec      <= 2'd0;
            r_ab       <= 2'b00;
            r_pass_cnt <= 4'd0;
            r_state    <= ST_WAIT;
          end
        end
        ST_SETTLE: begin
          if (w_expired) r_state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          r_fail_vec <= w_fail_nxt;
          if (r_vec != 2'd3) begin
            r_vec   <= r_vec + 2'd1;
            r_ab    <= r_vec + 2'd1;
            r_state <= ST_WAIT;
          end else if (!w_last) begin
            r_vec      <= 2'd0;
            r_ab       <= 2'b00;
            r_pass_cnt <= r_pass_cnt + 4'd1;
            r_state    <= ST_WAIT;
          end else begin
            // The verdict must include this final sample, hence w_fail_nxt.
            r_busy  <= 1'b0;
            r_pass  <= (w_fail_nxt == 8'h00);
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef GATE_SELFTEST_LOG_EN
  logic       r_ff_vld;
  logic [1:0] r_ff_ab;
  logic [7:0] r_ff_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ff_vld <= 1'b0;
      r_ff_ab  <= 2'b00;
      r_ff_res <= 8'h00;
    end else if (w_accept) begin
      r_ff_vld <= 1'b0;
      r_ff_ab  <= 2'b00;
      r_ff_res <= 8'h00;
    end else if ((r_state == ST_SAMPLE) && (w_mismatch != 8'h00) && !r_ff_vld) begin
      r_ff_vld <= 1'b1;
      r_ff_ab  <= r_ab;
      r_ff_res <= gate_bus.gate_res;
    end
  end

  assign first_fail_valid = r_ff_vld;
  assign first_fail_ab    = r_ff_ab;
  assign first_fail_res   = r_ff_res;
`endif

  assign gate_bus.gate_a = r_ab[1];
  assign gate_bus.gate_b = r_ab[0];
  assign busy            = r_busy;
  assign done            = (r_state == ST_DONE);
  assign pass            = r_pass;
  assign fail_vec        = r_fail_vec;

endmodule

// File: tb/tb_gate_selftest_seq.sv
// Bench for gate_selftest_seq: default instance with fault-injectable gate model, plus a
// SETTLE_CYCLES=0 / NUM_PASSES=2 instance; expectations are queued and checked on done.
module tb_gate_selftest_seq;

  typedef struct {
    logic [7:0] fv;
    logic       ps;
    int         lat;
    logic [1:0] ffab;
    logic [7:0] ffres;
    logic       ffv;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [7:0] sa0 = 8'h00;
  logic [7:0] sa1 = 8'h00;

  logic       start_s [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic       pass_s  [2];
  logic [7:0] fv_s    [2];
  logic [1:0] ab_s    [2];
  int         t0      [2];
  bit         ab_chk  [2];
  int         dones   [2];
  int         lat     [2];
  int         sett    [2];
  exp_t       q0[$];
  exp_t       q1[$];
`ifdef GATE_SELFTEST_LOG_EN
  logic       ffv_s   [2];
  logic [1:0] ffab_s  [2];
  logic [7:0] ffres_s [2];
`endif

  gate_selftest_seq_if bus0();
  gate_selftest_seq_if bus1();

  function automatic logic [7:0] ideal(input logic a, input logic b);
    return {~b, ~a, ~(a ^ b), ~(a | b), ~(a & b), a ^ b, a | b, a & b};
  endfunction

  assign bus0.gate_res = (ideal(bus0.gate_a, bus0.gate_b) & ~sa0) | sa1;
  assign bus1.gate_res = ideal(bus1.gate_a, bus1.gate_b);
  assign ab_s[0] = {bus0.gate_a, bus0.gate_b};
  assign ab_s[1] = {bus1.gate_a, bus1.gate_b};

  gate_selftest_seq u_dut0 (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start_s[0]),
    .gate_bus         (bus0),
    .busy             (busy_s[0]),
    .done             (done_s[0]),
    .pass             (pass_s[0]),
`ifdef GATE_SELFTEST_LOG_EN
    .first_fail_valid (ffv_s[0]),
    .first_fail_ab    (ffab_s[0]),
    .first_fail_res   (ffres_s[0]),
`endif
    .fail_vec         (fv_s[0])
  );

  gate_selftest_seq #(.SETTLE_CYCLES(0), .NUM_PASSES(2)) u_dut1 (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start_s[1]),
    .gate_bus         (bus1),
    .busy             (busy_s[1]),
    .done             (done_s[1]),
    .pass             (pass_s[1]),
`ifdef GATE_SELFTEST_LOG_EN
    .first_fail_valid (ffv_s[1]),
    .first_fail_ab    (ffab_s[1]),
    .first_fail_res   (ffres_s[1]),
`endif
    .fail_vec         (fv_s[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: pops one expectation per done pulse and checks the operand sweep while busy.
  task automatic mon(input int i);
    int   k;
    exp_t e;
    k = cyc - t0[i];
    if (ab_chk[i] && k < lat[i])
      chk($sformatf("ab_seq%0d_k%0d", i, k), {29'd0, busy_s[i], ab_s[i]},
          {29'd0, 1'b1, 2'((k / sett[i]) % 4)});
    if (done_s[i] === 1'b1) begin
      dones[i]++;
      if ((i == 0 ? q0.size() : q1.size()) == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_done%0d actual=done required=no_done at_edge=%0d", i, k);
      end else begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("done_edge%0d", i), k, e.lat);
        chk($sformatf("pass%0d", i), {31'd0, pass_s[i]}, {31'd0, e.ps});
        chk($sformatf("fail_vec%0d", i), {24'd0, fv_s[i]}, {24'd0, e.fv});
        chk($sformatf("busy_at_done%0d", i), {31'd0, busy_s[i]}, 32'd0);
`ifdef GATE_SELFTEST_LOG_EN
        chk($sformatf("ff_valid%0d", i), {31'd0, ffv_s[i]}, {31'd0, e.ffv});
        if (e.ffv) begin
          chk($sformatf("ff_ab%0d", i), {30'd0, ffab_s[i]}, {30'd0, e.ffab});
          chk($sformatf("ff_res%0d", i), {24'd0, ffres_s[i]}, {24'd0, e.ffres});
        end
`endif
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic run(input int i, input logic [7:0] fv, input logic ps, input logic [1:0] ffab,
                     input logic [7:0] ffres, input logic ffv, input bit chk_ab,
                     input int repulse, input int rst_at);
    exp_t e;
    int   n0;
    e.fv = fv; e.ps = ps; e.lat = lat[i]; e.ffab = ffab; e.ffres = ffres; e.ffv = ffv;
    if (rst_at <= 0) begin
      if (i == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    @(negedge clk) start_s[i] = 1'b1;
    @(posedge clk);
    #1;
    start_s[i] = 1'b0;
    t0[i] = cyc;
    ab_chk[i] = chk_ab;
    n0 = dones[i];
    if (repulse > 0) begin
      repeat (repulse - 1) @(posedge clk);
      @(negedge clk) start_s[i] = 1'b1;
      @(posedge clk);
      #1 start_s[i] = 1'b0;
    end
    if (rst_at > 0) begin
      repeat (rst_at) @(posedge clk);
      #1 rst_n = 1'b0;
      ab_chk[i] = 1'b0;
      #1 chk("reset_midrun_outputs", {19'd0, ab_s[i], busy_s[i], done_s[i], pass_s[i], fv_s[i]}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("no_done_after_abort", dones[i] - n0, 32'd0);
      return;
    end
    for (int c = 0; c < 60 && dones[i] == n0; c++) @(posedge clk);
    chk($sformatf("done_seen%0d", i), dones[i] - n0, 32'd1);
    ab_chk[i] = 1'b0;
    repeat (10) @(negedge clk);
    chk($sformatf("single_done%0d", i), dones[i] - n0, 32'd1);
    chk($sformatf("result_hold%0d", i), {23'd0, fv_s[i], pass_s[i]}, {23'd0, fv, ps});
  endtask

  initial begin
    start_s[0] = 1'b0; start_s[1] = 1'b0;
    t0[0] = 0; t0[1] = 0;
    ab_chk[0] = 1'b0; ab_chk[1] = 1'b0;
    dones[0] = 0; dones[1] = 0;
    lat[0] = 12; lat[1] = 8;
    sett[0] = 3; sett[1] = 1;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++)
      chk($sformatf("reset_state%0d", i),
          {19'd0, ab_s[i], busy_s[i], done_s[i], pass_s[i], fv_s[i]}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Healthy gate block
    run(0, 8'h00, 1'b1, 2'b00, 8'h00, 1'b0, 1'b1, 0, 0);
    // and_out stuck at 0: only ab=11 differs; raw bundle there is 8'h22
    sa0 = 8'h01;
    run(0, 8'h01, 1'b0, 2'b11, 8'h22, 1'b1, 1'b0, 0, 0);
    // not_a stuck at 1: ab=10 and ab=11 differ; raw bundle at ab=10 is 8'hCE
    sa0 = 8'h00; sa1 = 8'h40;
    run(0, 8'h40, 1'b0, 2'b10, 8'hCE, 1'b1, 1'b0, 0, 0);
    sa1 = 8'h00;
    // start re-pulsed at edge 5 is ignored
    run(0, 8'h00, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 5, 0);
    // reset at edge 7 aborts, then a clean run
    run(0, 8'h00, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 0, 7);
    run(0, 8'h00, 1'b1, 2'b00, 8'h00, 1'b0, 1'b1, 0, 0);
    // No settle time, two sweeps
    run(1, 8'h00, 1'b1, 2'b00, 8'h00, 1'b0, 1'b1, 0, 0);

    repeat (5) @(negedge clk);
    chk("queue0_drained", q0.size(), 32'd0);
    chk("queue1_drained", q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
